// File: rtl/vram_sync_ctrl.sv
// rtl/vram_sync_ctrl.sv - vblank-gated CPU-VRAM to PPU-VRAM bulk copy controller.
// Optional macro VRAM_SYNC_CPU_STALL_EN drives cpu_stall during COPY/DRAIN; otherwise it is tied 0.
module vram_sync_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 64,
  parameter int COPY_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_req,
  input  logic              vblank_start,
  output logic              c_rd_en,
  output logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_rdata,
  output logic              p_wr_en,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_wdata,
  output logic              sync_busy,
  output logic              sync_done,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {IDLE, ARMED, COPY, DRAIN} state_e;

  // Compare against the last index so COPY_WORDS == 2**ADDR_W never relies on wrap-around.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COPY_WORDS - 1);

  state_e              state_q;
  logic                pend_q;
  logic                c_rd_en_q;
  logic [ADDR_W-1:0]   c_addr_q;
  logic                p_wr_en_q;
  logic [ADDR_W-1:0]   p_addr_q;
  logic                done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      c_rd_en_q <= 1'b0;
      c_addr_q  <= '0;
      p_wr_en_q <= 1'b0;
      p_addr_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sync_req) state_q <= ARMED;
        end
        ARMED: begin
          if (vblank_start) begin
            state_q   <= COPY;
            c_rd_en_q <= 1'b1;
            c_addr_q  <= '0;
          end
        end
        COPY: begin
          if (sync_req) pend_q <= 1'b1;
          // Write k lands the cycle after read k, when its data appears on c_rdata.
          p_wr_en_q <= 1'b1;
          p_addr_q  <= c_addr_q;
          if (c_addr_q == LAST_ADDR) begin
            state_q   <= DRAIN;
            c_rd_en_q <= 1'b0;
            c_addr_q  <= '0;
            done_q    <= 1'b1;
          end else begin
            c_addr_q  <= c_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          p_wr_en_q <= 1'b0;
          p_addr_q  <= '0;
          done_q    <= 1'b0;
          pend_q    <= 1'b0;
          state_q   <= (pend_q || sync_req) ? ARMED : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c_rd_en   = c_rd_en_q;
  assign c_addr    = c_addr_q;
  assign p_wr_en   = p_wr_en_q;
  assign p_addr    = p_addr_q;
  assign p_wdata   = p_wr_en_q ? c_rdata : '0;
  assign sync_busy = (state_q == ARMED) || (state_q == COPY);
  assign sync_done = done_q;

`ifdef VRAM_SYNC_CPU_STALL_EN
  assign cpu_stall = (state_q == COPY) || (state_q == DRAIN);
`else
  assign cpu_stall = 1'b0;
`endif

endmodule

// File: doc/vram_sync_ctrl.md
VRAM_SYNC_CTRL -- requirements
Module: vram_sync_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, VRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, VRAM word width.
REQ-003 SHALL have parameter COPY_WORDS, default 4096, number of words copied per sync (1..2^ADDR_W).
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sync_req  input  1  CPU pulse requesting CPU-VRAM to PPU-VRAM commit.
REQ-007 SHALL have port vblank_start  input  1  single-cycle pulse at start of vertical blank.
REQ-008 SHALL have port c_rd_en  output  1  read strobe to CPU-facing VRAM copy port.
REQ-009 SHALL have port c_addr  output  ADDR_W  read address to CPU-facing VRAM.
REQ-010 SHALL have port c_rdata  input  DATA_W  CPU-facing VRAM read data, valid one cycle after c_rd_en.
REQ-011 SHALL have port p_wr_en  output  1  write strobe to PPU-facing VRAM.
REQ-012 SHALL have port p_addr  output  ADDR_W  write address to PPU-facing VRAM.
REQ-013 SHALL have port p_wdata  output  DATA_W  write data to PPU-facing VRAM.
REQ-014 SHALL have port sync_busy  output  1  high in ARMED or COPY.
REQ-015 SHALL have port sync_done  output  1  one-cycle pulse when a copy completes.
REQ-016 SHALL have port cpu_stall  output  1  CPU VRAM write hold (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, ARMED, COPY, DRAIN.
REQ-018 IDLE -> ARMED on sync_req; vblank_start in IDLE SHALL be ignored.
REQ-019 sync_req and vblank_start in the same IDLE cycle SHALL go to ARMED only; copy waits for next vblank_start.
REQ-020 ARMED -> COPY on vblank_start; sync_req in ARMED SHALL be ignored (no queueing).
REQ-021 In COPY, read counter k SHALL start at 0; each cycle c_rd_en=1, c_addr=k, k increments; after k=COPY_WORDS-1 issued, -> DRAIN.
REQ-022 Write path SHALL be one cycle behind read: p_wr_en=1, p_addr=k, p_wdata=c_rdata the cycle after read k; p_wdata driven combinationally from c_rdata.
REQ-023 DRAIN SHALL last one cycle performing final write, assert sync_done that cycle, then -> IDLE, or -> ARMED if a sync_req arrived during COPY/DRAIN.
REQ-024 Total copy SHALL occupy COPY_WORDS+1 cycles from first c_rd_en to sync_done inclusive.
REQ-025 sync_req during COPY/DRAIN SHALL set a single pending flag; multiple requests SHALL collapse to one.
REQ-026 vblank_start during COPY/DRAIN SHALL be ignored.
REQ-027 Address counter SHALL be ADDR_W bits; COPY_WORDS=2^ADDR_W SHALL terminate via compare to COPY_WORDS-1, not overflow.
REQ-028 c_rd_en, p_wr_en SHALL be 0 outside COPY/DRAIN respectively; c_addr, p_addr SHALL be 0 when idle.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, pending flag 0, counter 0, all outputs 0.
REQ-030 Reset mid-COPY SHALL abort without sync_done; partially written PPU-VRAM contents are unspecified.
REQ-031 After rst_n deasserts, first sync_req SHALL be honored in the next cycle.

Configuration
REQ-032 Macro VRAM_SYNC_CPU_STALL_EN defined: cpu_stall SHALL be 1 exactly in cycles where state is COPY or DRAIN.
REQ-033 Macro VRAM_SYNC_CPU_STALL_EN undefined: cpu_stall SHALL be tied 0; CPU write coherency during copy is software's responsibility.

Verification
REQ-034 COPY_WORDS=8, C-VRAM word i=0xA0+i, sync_req then vblank_start 5 cycles later -> c_addr 0..7 on 8 consecutive cycles, P-VRAM words 0..7 = 0xA0..0xA7, sync_done on 9th cycle.
REQ-035 vblank_start with no prior sync_req -> no c_rd_en, no p_wr_en, sync_busy stays 0.
REQ-036 sync_req and vblank_start same cycle -> sync_busy=1, no copy until next vblank_start; then full 8-word copy.
REQ-037 Three sync_req pulses during COPY -> after sync_done state ARMED; next vblank_start yields exactly one further copy.
REQ-038 rst_n low at copy word 3 -> all outputs 0 asynchronously, no sync_done, state IDLE after release.
REQ-039 With VRAM_SYNC_CPU_STALL_EN, cpu_stall high exactly 9 cycles per copy; without, cpu_stall constant 0.
